// File: rtl/holy_core_pkg.sv
// Shared trap definitions for the core: scheduler state, interrupt cause
// codes, mie/mip bit positions and the mtvec mode encoding.
package holy_core_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } trap_state_t;

  localparam logic [30:0] CAUSE_MEI = 31'd11;
  localparam logic [30:0] CAUSE_MSI = 31'd3;
  localparam logic [30:0] CAUSE_MTI = 31'd7;

  // The same bit positions index both mie and mip.
  localparam int MEI_BIT = 11;
  localparam int MSI_BIT = 3;
  localparam int MTI_BIT = 7;

  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

  typedef struct packed {
    logic        is_irq;
    logic [30:0] cause;
    logic [31:0] epc;
  } trap_req_t;

endpackage

// File: rtl/trap_scheduler_if.sv
// Bundle between the trap scheduler and the control unit / CSR file / PC select.
// master = the core side driving requests, slave = the scheduler.
interface trap_scheduler_if;
  logic        stall_i;
  logic [31:0] pc_i;
  logic        exception_i;
  logic [30:0] exception_cause_i;
  logic        m_ret_i;
  logic        irq_ext_i;
  logic        irq_timer_i;
  logic        irq_soft_i;
  logic        mstatus_mie_i;
  logic [31:0] mie_i;
  logic [31:0] mtvec_i;
  logic [31:0] mepc_i;

  logic        trap_o;
  logic [31:0] trap_target_o;
  logic [31:0] mcause_o;
  logic [31:0] mepc_o;
  logic        csr_trap_we_o;
  logic        mret_o;
  logic        flush_o;
  logic [31:0] mip_o;
  logic        busy_o;

  modport master (
    output stall_i, pc_i, exception_i, exception_cause_i, m_ret_i,
           irq_ext_i, irq_timer_i, irq_soft_i, mstatus_mie_i, mie_i,
           mtvec_i, mepc_i,
    input  trap_o, trap_target_o, mcause_o, mepc_o, csr_trap_we_o,
           mret_o, flush_o, mip_o, busy_o
  );

  modport slave (
    input  stall_i, pc_i, exception_i, exception_cause_i, m_ret_i,
           irq_ext_i, irq_timer_i, irq_soft_i, mstatus_mie_i, mie_i,
           mtvec_i, mepc_i,
    output trap_o, trap_target_o, mcause_o, mepc_o, csr_trap_we_o,
           mret_o, flush_o, mip_o, busy_o
  );
endinterface

// File: rtl/trap_scheduler_irq_sync.sv
// N-flop synchronizer for an asynchronous level input, with synchronous
// active-high clear.
module irq_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge value of its neighbour; = here would collapse the chain.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/trap_scheduler.sv
// Trap entry / MRET sequencer: fixed-priority exception and interrupt arbiter
// with stall hold-over. Define TRAP_VECTORED_EN for vectored interrupt targets.
module trap_scheduler
  import holy_core_pkg::*;
#(
  parameter int          IRQ_SYNC_STAGES = 2,
  parameter logic [31:0] RESET_VECTOR    = 32'h0000_0000
) (
  input logic              clk,
  input logic              rst,
  trap_scheduler_if.slave  bus
);

  trap_state_t state_q, state_d;
  trap_req_t   latch_q, cur_req, commit_req;
  logic        cur_valid;
  logic        commit;
  logic        mret_take;
  logic        holdoff_q;
  logic        ext_sync;
  logic [31:0] mip;
  logic        irq_en, mei_ok, msi_ok, mti_ok;
  logic [31:0] base_target, trap_target;

  irq_sync #(.STAGES(IRQ_SYNC_STAGES)) u_ext_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.irq_ext_i),
    .q   (ext_sync)
  );

  assign mip = {20'b0, ext_sync, 3'b0, bus.irq_timer_i, 3'b0, bus.irq_soft_i, 3'b0};

  // holdoff covers the cycle in which the CSR file has not yet cleared MIE.
  assign irq_en = bus.mstatus_mie_i & ~holdoff_q;
  assign mei_ok = irq_en & bus.mie_i[MEI_BIT] & mip[MEI_BIT];
  assign msi_ok = irq_en & bus.mie_i[MSI_BIT] & mip[MSI_BIT];
  assign mti_ok = irq_en & bus.mie_i[MTI_BIT] & mip[MTI_BIT];

  // NOTE: every signal written in always_comb gets a default on entry, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cur_valid      = 1'b1;
    cur_req.is_irq = 1'b1;
    cur_req.cause  = '0;
    cur_req.epc    = bus.pc_i;
    if (bus.exception_i) begin
      cur_req.is_irq = 1'b0;
      cur_req.cause  = bus.exception_cause_i;
    end else if (mei_ok) begin
      cur_req.cause  = CAUSE_MEI;
    end else if (msi_ok) begin
      cur_req.cause  = CAUSE_MSI;
    end else if (mti_ok) begin
      cur_req.cause  = CAUSE_MTI;
    end else begin
      cur_valid      = 1'b0;
      cur_req.is_irq = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    commit     = 1'b0;
    mret_take  = 1'b0;
    commit_req = cur_req;
    case (state_q)
      IDLE: begin
        if (cur_valid) begin
          if (bus.stall_i) state_d = PENDING;
          else             commit  = 1'b1;
        end else if (bus.m_ret_i && !bus.stall_i) begin
          mret_take = 1'b1;
        end
      end
      PENDING: begin
        // The latched request is final: new events are ignored until it commits.
        commit_req = latch_q;
        if (!bus.stall_i) begin
          commit  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      latch_q   <= '0;
      holdoff_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      holdoff_q <= commit;
      if (state_q == IDLE && cur_valid && bus.stall_i) latch_q <= cur_req;
    end
  end

  assign base_target = {bus.mtvec_i[31:2], 2'b00};

`ifdef TRAP_VECTORED_EN
  always_comb begin
    trap_target = base_target;
    if (commit_req.is_irq && bus.mtvec_i[1:0] == MTVEC_MODE_VECTORED)
      trap_target = base_target + {commit_req.cause[29:0], 2'b00};
  end
`else
  assign trap_target = base_target;
  logic unused_mtvec_mode;
  assign unused_mtvec_mode = ^bus.mtvec_i[1:0];
`endif

  logic unused_mie_bits;
  assign unused_mie_bits = ^{bus.mie_i[31:12], bus.mie_i[10:8], bus.mie_i[6:4], bus.mie_i[2:0]};

  // Reset is synchronous, so outputs are forced quiet directly while rst is high.
  always_comb begin
    bus.trap_o        = 1'b0;
    bus.csr_trap_we_o = 1'b0;
    bus.flush_o       = 1'b0;
    bus.mret_o        = 1'b0;
    bus.busy_o        = 1'b0;
    bus.mip_o         = '0;
    bus.mcause_o      = '0;
    bus.mepc_o        = '0;
    bus.trap_target_o = RESET_VECTOR;
    if (!rst) begin
      bus.trap_o        = commit;
      bus.csr_trap_we_o = commit;
      bus.flush_o       = commit;
      bus.mret_o        = mret_take;
      bus.busy_o        = (state_q == PENDING);
      bus.mip_o         = mip;
      bus.mcause_o      = {commit_req.is_irq, commit_req.cause};
      bus.mepc_o        = commit_req.epc;
      bus.trap_target_o = mret_take ? bus.mepc_i : trap_target;
    end
  end

endmodule
